// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared MIPS opcode/funct codes, forwarding select encodings, FSM states and
// the IF/ID instruction decoder used by the hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  localparam logic [1:0] FWD_WB    = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       rs_use;
    logic       rt_use;
    logic       load;
    logic       is_j;
  } decode_t;

  // r0 is hardwired, so it is stripped both as a source and as a destination
  function automatic decode_t decode_ir(input logic [31:0] ir, input logic valid);
    decode_t d;
    d    = '0;
    d.rs = ir[25:21];
    d.rt = ir[20:16];
    case (ir[31:26])
      OP_RTYPE: begin
        if (ir[5:0] == FN_ADD || ir[5:0] == FN_SUB || ir[5:0] == FN_SLT) begin
          d.rs_use = 1'b1;
          d.rt_use = 1'b1;
          d.dst    = ir[15:11];
        end
      end
      OP_LW: begin
        d.rs_use = 1'b1;
        d.dst    = ir[20:16];
        d.load   = 1'b1;
      end
      OP_SW, OP_BEQ: begin
        d.rs_use = 1'b1;
        d.rt_use = 1'b1;
      end
      OP_J:    d.is_j = 1'b1;
      default: d.is_j = 1'b0;
    endcase
    if (d.rs == 5'd0) d.rs_use = 1'b0;
    if (d.rt == 5'd0) d.rt_use = 1'b0;
    if (d.dst == 5'd0) d.load = 1'b0;
    if (!valid) d = '0;
    return d;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [2:0] hit);
    if (hit[0])      return FWD_EXMEM;
    else if (hit[1]) return FWD_MEMWB;
    else if (hit[2]) return FWD_WB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Destination-register history for EX/MEM/WB and the per-stage source match
// vectors (bit 0 = EX, bit 1 = MEM, bit 2 = WB) for rs and rt.
module pipeline_hazard_ctrl_scoreboard (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bubble,
  input  logic [4:0] id_dst,
  input  logic       id_ld,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       rs_use,
  input  logic       rt_use,
  output logic       ex_ld,
  output logic [2:0] hit_rs,
  output logic [2:0] hit_rt
);

  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ex_ld_q, ex_ld_d;
  logic [4:0] mem_rd_q, mem_rd_d;
  logic [4:0] wb_rd_q, wb_rd_d;

  always_comb begin
    ex_rd_d  = bubble ? 5'd0 : id_dst;
    ex_ld_d  = bubble ? 1'b0 : id_ld;
    mem_rd_d = ex_rd_q;
    wb_rd_d  = mem_rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q  <= 5'd0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= 5'd0;
      wb_rd_q  <= 5'd0;
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_ld_q  <= ex_ld_d;
      mem_rd_q <= mem_rd_d;
      wb_rd_q  <= wb_rd_d;
    end
  end

  // Sources are already non-zero when used, so an empty (0) slot never matches
  always_comb begin
    hit_rs = {rs_use && (rs == wb_rd_q), rs_use && (rs == mem_rd_q), rs_use && (rs == ex_rd_q)};
    hit_rt = {rt_use && (rt == wb_rd_q), rt_use && (rt == mem_rd_q), rt_use && (rt == ex_rd_q)};
  end

  assign ex_ld = ex_ld_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: stall/flush/bubble FSM plus
// registered forwarding selects. Define FWD_EN to build with forwarding.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int BR_FLUSH_CYC = 2,
  parameter int J_FLUSH_CYC  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_ir,
  input  logic        id_valid,
  input  logic        ex_br_taken,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel
);

  localparam logic [1:0] BR_CNT = 2'(BR_FLUSH_CYC - 1);
  localparam logic [1:0] J_CNT  = 2'(J_FLUSH_CYC - 1);

  decode_t    dec;
  logic [2:0] hit_rs, hit_rt;
  logic       ex_ld;
  logic       load_use, stall_hzd;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       br_mode_q, br_mode_d;
  logic       pc_stall_c, ifid_stall_c, ifid_flush_c, idex_bubble_c;

  assign dec = decode_ir(id_ir, id_valid);

  pipeline_hazard_ctrl_scoreboard u_scoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (idex_bubble_c),
    .id_dst (dec.dst),
    .id_ld  (dec.load),
    .rs     (dec.rs),
    .rt     (dec.rt),
    .rs_use (dec.rs_use),
    .rt_use (dec.rt_use),
    .ex_ld  (ex_ld),
    .hit_rs (hit_rs),
    .hit_rt (hit_rt)
  );

  assign load_use = ex_ld && (hit_rs[0] || hit_rt[0]);

`ifdef FWD_EN
  assign stall_hzd = load_use;
`else
  assign stall_hzd = load_use || (|hit_rs) || (|hit_rt);
`endif

  // A taken branch always wins, even mid-flush, since it is the older instruction
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    br_mode_d     = br_mode_q;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    if (ex_br_taken) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      br_mode_d     = 1'b1;
      cnt_d         = BR_CNT;
      state_d       = (BR_CNT == 2'd0) ? ST_RUN : ST_FLUSH;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = br_mode_q;
          cnt_d         = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
          if (cnt_q <= 2'd1) state_d = ST_RUN;
        end
        ST_STALL: begin
`ifdef FWD_EN
          state_d = ST_RUN;
`else
          if (stall_hzd) begin
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_bubble_c = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
`endif
        end
        default: begin
          if (stall_hzd) begin
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_bubble_c = 1'b1;
            state_d       = ST_STALL;
          end else if (dec.is_j) begin
            ifid_flush_c = 1'b1;
            br_mode_d    = 1'b0;
            cnt_d        = J_CNT;
            state_d      = (J_CNT == 2'd0) ? ST_RUN : ST_FLUSH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= 2'd0;
      br_mode_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      br_mode_q <= br_mode_d;
    end
  end

  assign pc_stall    = rst_n & pc_stall_c;
  assign ifid_stall  = rst_n & ifid_stall_c;
  assign ifid_flush  = rst_n & ifid_flush_c;
  assign idex_bubble = rst_n & idex_bubble_c;

`ifdef FWD_EN
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  // Selects travel with the operands into ID/EX, so a bubble carries no forwarding
  always_comb begin
    fwd_a_d = idex_bubble_c ? FWD_RF : fwd_sel(hit_rs);
    fwd_b_d = idex_bubble_c ? FWD_RF : fwd_sel(hit_rt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
`else
  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl; expected values follow the FWD_EN
// build setting (default: no-forward build with RAW stalls).
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_ir;
  logic        id_valid;
  logic        ex_br_taken;
  logic        pc_stall, ifid_stall, ifid_flush, idex_bubble;
  logic [1:0]  fwd_a_sel, fwd_b_sel;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_ir       (id_ir),
    .id_valid    (id_valid),
    .ex_br_taken (ex_br_taken),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel)
  );

  typedef struct packed {
    logic [3:0] ctl;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;

  exp_t expQueue[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rt, input logic [4:0] rs);
    return {6'd35, rs, rt, 16'd0};
  endfunction

  function automatic logic [31:0] beq(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd4, rs, rt, 16'd8};
  endfunction

  function automatic logic [31:0] jmp();
    return {6'd2, 26'h40};
  endfunction

  // Every comparison in the bench goes through here
  task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, got, want);
    end
  endtask

  // Drive one cycle of IF/ID contents, queue the expected response, check it mid-cycle
  task automatic applyStimulus(input string name, input logic rstn, input logic [31:0] ir,
                               input logic valid, input logic br, input logic [3:0] ctl,
                               input logic [1:0] a, input logic [1:0] b);
    exp_t e;
    rst_n       = rstn;
    id_ir       = ir;
    id_valid    = valid;
    ex_br_taken = br;
    expQueue.push_back('{ctl: ctl, a: a, b: b});
    @(negedge clk);
    if (expQueue.size() == 0) begin
      checkOutput({name, ".queue"}, 4'd0, 4'd1);
    end else begin
      e = expQueue.pop_front();
      checkOutput({name, ".ctl"}, {pc_stall, ifid_stall, ifid_flush, idex_bubble}, e.ctl);
      checkOutput({name, ".fwd_a"}, {2'b00, fwd_a_sel}, {2'b00, e.a});
      checkOutput({name, ".fwd_b"}, {2'b00, fwd_b_sel}, {2'b00, e.b});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) applyStimulus(name, 1'b1, 32'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    id_ir       = 32'd0;
    id_valid    = 1'b0;
    ex_br_taken = 1'b0;

    applyStimulus("reset0", 1'b0, rtype(FN_ADD, 5'd3, 5'd1, 5'd2), 1'b1, 1'b1, 4'b0000, 2'd0, 2'd0);
    applyStimulus("reset1", 1'b0, 32'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
    idle("post_reset", 2);

`ifdef FWD_EN
    applyStimulus("fwd.c0", 1'b1, rtype(FN_ADD, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("fwd.c1", 1'b1, rtype(FN_SUB, 5'd4, 5'd3, 5'd5), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("fwd.c2", 1'b1, 32'd0, 1'b0, 1'b0, 4'b0000, 2'd1, 2'd0);
    applyStimulus("fwd.c3", 1'b1, rtype(FN_ADD, 5'd6, 5'd3, 5'd4), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("fwd.c4", 1'b1, 32'd0, 1'b0, 1'b0, 4'b0000, 2'd3, 2'd2);
    applyStimulus("fwd.c5", 1'b1, 32'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
    idle("fwd.idle", 3);

    applyStimulus("ldu.c0", 1'b1, lw(5'd2, 5'd1), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("ldu.c1", 1'b1, rtype(FN_ADD, 5'd4, 5'd2, 5'd2), 1'b1, 1'b0, 4'b1101, 2'd0, 2'd0);
    applyStimulus("ldu.c2", 1'b1, rtype(FN_ADD, 5'd4, 5'd2, 5'd2), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("ldu.c3", 1'b1, 32'd0, 1'b0, 1'b0, 4'b0000, 2'd2, 2'd2);
    applyStimulus("ldu.c4", 1'b1, 32'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
    idle("ldu.idle", 3);
`else
    for (int i = 0; i < 5; i++) begin
      applyStimulus("raw.c0", 1'b1, (i == 0) ? rtype(FN_ADD, 5'd3, 5'd1, 5'd2) : rtype(FN_ADD, 5'd5, 5'd3, 5'd3),
                    1'b1, 1'b0, (i == 0 || i == 4) ? 4'b0000 : 4'b1101, 2'd0, 2'd0);
    end
    applyStimulus("raw.c5", 1'b1, 32'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
    idle("raw.idle", 3);

    applyStimulus("ldu.c0", 1'b1, lw(5'd2, 5'd1), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    for (int i = 1; i < 5; i++) begin
      applyStimulus("ldu.stall", 1'b1, rtype(FN_ADD, 5'd4, 5'd2, 5'd2), 1'b1, 1'b0,
                    (i == 4) ? 4'b0000 : 4'b1101, 2'd0, 2'd0);
    end
    idle("ldu.idle", 3);
`endif

    applyStimulus("beq.c0", 1'b1, beq(5'd1, 5'd1), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("beq.c1", 1'b1, rtype(FN_ADD, 5'd7, 5'd1, 5'd2), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("beq.taken", 1'b1, rtype(FN_ADD, 5'd8, 5'd7, 5'd7), 1'b1, 1'b1, 4'b0011, 2'd0, 2'd0);
    applyStimulus("beq.restart", 1'b1, 32'd0, 1'b0, 1'b1, 4'b0011, 2'd0, 2'd0);
    applyStimulus("beq.flush2", 1'b1, 32'd0, 1'b0, 1'b0, 4'b0011, 2'd0, 2'd0);
    applyStimulus("beq.run", 1'b1, 32'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
    idle("beq.idle", 2);

    applyStimulus("j.decode", 1'b1, jmp(), 1'b1, 1'b0, 4'b0010, 2'd0, 2'd0);
    applyStimulus("j.after", 1'b1, rtype(FN_ADD, 5'd9, 5'd1, 5'd2), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("r0.prod", 1'b1, rtype(FN_ADD, 5'd0, 5'd1, 5'd2), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("r0.cons", 1'b1, rtype(FN_ADD, 5'd10, 5'd0, 5'd0), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("r0.sel", 1'b1, 32'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("j.invalid", 1'b1, jmp(), 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
    idle("j.idle", 3);

`ifdef FWD_EN
    applyStimulus("rst.c0", 1'b1, rtype(FN_ADD, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("rst.c1", 1'b1, rtype(FN_ADD, 5'd6, 5'd3, 5'd3), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("rst.sel", 1'b0, 32'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("rst.lw", 1'b1, lw(5'd2, 5'd1), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("rst.stall", 1'b0, rtype(FN_ADD, 5'd4, 5'd2, 5'd2), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("rst.release", 1'b1, rtype(FN_ADD, 5'd4, 5'd2, 5'd2), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
`else
    applyStimulus("rst.c0", 1'b1, rtype(FN_ADD, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("rst.c1", 1'b1, rtype(FN_ADD, 5'd5, 5'd3, 5'd3), 1'b1, 1'b0, 4'b1101, 2'd0, 2'd0);
    applyStimulus("rst.stall", 1'b0, rtype(FN_ADD, 5'd5, 5'd3, 5'd3), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("rst.release", 1'b1, rtype(FN_ADD, 5'd5, 5'd3, 5'd3), 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0);
`endif
    idle("rst.idle", 3);

    applyStimulus("rstf.taken", 1'b1, 32'd0, 1'b0, 1'b1, 4'b0011, 2'd0, 2'd0);
    applyStimulus("rstf.flush", 1'b0, 32'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("rstf.release", 1'b1, 32'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
    applyStimulus("rstf.run", 1'b1, 32'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
